// File: rtl/hwpe_ctrl_uloop_hs_if.sv
// Offset/index tuple handshake between the micro-loop sequencer and its consumer.
// The master drives valid, offs and idx; the slave returns ready.
interface hwpe_ctrl_uloop_hs_if #(
  parameter int unsigned NB_REG    = 4,
  parameter int unsigned NB_LOOPS  = 6,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                                valid;
  logic                                ready;
  logic [NB_REG-1:0][REG_WIDTH-1:0]    offs;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]  idx;

  modport master (output valid, offs, idx, input ready);
  modport slave  (input valid, offs, idx, output ready);
endinterface

// File: rtl/hwpe_ctrl_uloop_hs.sv
// Nested-loop microcode sequencer: emits offset/index tuples, runs one loop body per handshake.
// Optional SUB opcode enabled by defining HWPE_CTRL_ULOOP_SUB_EN (otherwise opcode 10 is a NOP).
module hwpe_ctrl_uloop_hs #(
  parameter int unsigned LENGTH    = 16,
  parameter int unsigned NB_LOOPS  = 6,
  parameter int unsigned NB_REG    = 4,
  parameter int unsigned NB_RO_REG = 28,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16,
  localparam int unsigned AW  = $clog2(NB_REG),
  localparam int unsigned BW  = $clog2(NB_REG + NB_RO_REG),
  localparam int unsigned IW  = 2 + AW + BW,
  localparam int unsigned LAW = $clog2(LENGTH)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic                                 start_i,
  input  logic [LENGTH-1:0][IW-1:0]            code_i,
  input  logic [NB_LOOPS-1:0][LAW-1:0]         loop_addr_i,
  input  logic [NB_LOOPS-1:0][LAW:0]           loop_nops_i,
  input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   range_i,
  input  logic [NB_RO_REG-1:0][REG_WIDTH-1:0]  ro_reg_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  hwpe_ctrl_uloop_hs_if.master                 hs
);

  localparam int unsigned LW = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1;
  localparam int unsigned RW = (NB_RO_REG > 1) ? $clog2(NB_RO_REG) : 1;
  localparam logic [BW:0] REG_LIM = (BW+1)'(NB_REG);
  localparam logic [BW:0] RO_LIM  = (BW+1)'(NB_REG + NB_RO_REG);

  typedef enum logic [1:0] {IDLE, VALID, EXEC} state_t;

  state_t                              state_q;
  logic                                valid_q, done_q, busy_q;
  logic [NB_REG-1:0][REG_WIDTH-1:0]    offs_q;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]  idx_q;
  logic [LAW-1:0]                      pc_q;
  logic [LAW:0]                        ops_q;

  // Smallest loop that can still advance; ranges of zero behave as one.
  logic [NB_LOOPS-1:0][CNT_WIDTH:0] rng_eff;
  logic                             inc_found;
  logic [LW-1:0]                    inc_loop;

  always_comb begin
    rng_eff   = '0;
    inc_found = 1'b0;
    inc_loop  = '0;
    for (int l = NB_LOOPS - 1; l >= 0; l--) begin
      rng_eff[l] = (range_i[l] == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, range_i[l]};
      if ({1'b0, idx_q[l]} + (CNT_WIDTH+1)'(1) < rng_eff[l]) begin
        inc_found = 1'b1;
        inc_loop  = LW'(l);
      end
    end
  end

  logic [IW-1:0]        instr;
  logic [1:0]           op;
  logic [AW-1:0]        ra;
  logic [BW-1:0]        rb;
  logic [BW:0]          ro_full;
  logic [REG_WIDTH-1:0] opnd;
  logic [REG_WIDTH-1:0] alu_res;
  logic                 alu_wr;

  assign instr   = code_i[pc_q];
  assign op      = instr[IW-1 -: 2];
  assign ra      = instr[BW +: AW];
  assign rb      = instr[BW-1:0];
  assign ro_full = {1'b0, rb} - REG_LIM;

  // Operand space: writable registers first, then the read-only bank.
  always_comb begin
    opnd = '0;
    if ({1'b0, rb} < REG_LIM)
      opnd = offs_q[rb[AW-1:0]];
    else if ({1'b0, rb} < RO_LIM)
      opnd = ro_reg_i[ro_full[RW-1:0]];
  end

  always_comb begin
    alu_res = offs_q[ra];
    alu_wr  = 1'b0;
    case (op)
      2'b00: begin
        alu_res = opnd;
        alu_wr  = 1'b1;
      end
      2'b01: begin
        alu_res = offs_q[ra] + opnd;
        alu_wr  = 1'b1;
      end
`ifdef HWPE_CTRL_ULOOP_SUB_EN
      2'b10: begin
        alu_res = offs_q[ra] - opnd;
        alu_wr  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      offs_q  <= '0;
      idx_q   <= '0;
      pc_q    <= '0;
      ops_q   <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      offs_q  <= '0;
      idx_q   <= '0;
      pc_q    <= '0;
      ops_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= VALID;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            offs_q  <= '0;
            idx_q   <= '0;
          end
        end
        VALID: begin
          if (hs.ready) begin
            if (inc_found) begin
              for (int j = 0; j < NB_LOOPS; j++) begin
                if (LW'(j) < inc_loop)
                  idx_q[j] <= '0;
                else if (LW'(j) == inc_loop)
                  idx_q[j] <= idx_q[j] + CNT_WIDTH'(1);
              end
              // An empty body re-presents the next tuple immediately.
              if (loop_nops_i[inc_loop] != '0) begin
                state_q <= EXEC;
                valid_q <= 1'b0;
                pc_q    <= loop_addr_i[inc_loop];
                ops_q   <= loop_nops_i[inc_loop];
              end
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (alu_wr)
            offs_q[ra] <= alu_res;
          pc_q  <= (pc_q == LAW'(LENGTH - 1)) ? '0 : pc_q + LAW'(1);
          ops_q <= ops_q - (LAW+1)'(1);
          if (ops_q == (LAW+1)'(1)) begin
            state_q <= VALID;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hs.valid = valid_q;
  assign hs.offs  = offs_q;
  assign hs.idx   = idx_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_hwpe_ctrl_uloop_hs.sv
// Directed bench for the micro-loop sequencer: two-level loop nest, stalls, clear, reset, SUB opcode.
module tb_hwpe_ctrl_uloop_hs;

  logic clk_i = 1'b0;
  logic rst_ni, clear_i, start_i;
  logic [15:0][8:0]  code;
  logic [1:0][3:0]   loop_addr;
  logic [1:0][4:0]   loop_nops;
  logic [1:0][15:0]  range_v;
  logic [27:0][31:0] ro;
  logic busy_o, done_o;
  int total = 0;
  int bad   = 0;

`ifdef HWPE_CTRL_ULOOP_SUB_EN
  localparam logic [31:0] SUB_EXP = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SUB_EXP = 32'h0;
`endif

  hwpe_ctrl_uloop_hs_if #(.NB_REG(4), .NB_LOOPS(2), .REG_WIDTH(32), .CNT_WIDTH(16)) hs ();

  hwpe_ctrl_uloop_hs #(.NB_LOOPS(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .code_i      (code),
    .loop_addr_i (loop_addr),
    .loop_nops_i (loop_nops),
    .range_i     (range_v),
    .ro_reg_i    (ro),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .hs          (hs)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!hs.valid && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, 32'(hs.valid), 32'd1);
  endtask

  // Check the presented tuple, then handshake it; returns on the negedge after the handshake edge.
  task automatic tuple(input string tag, input logic [31:0] r0, input logic [15:0] i0, input logic [15:0] i1);
    wait_valid({tag, "_vld"});
    chk({tag, "_r0"}, hs.offs[0], r0);
    chk({tag, "_i0"}, 32'(hs.idx[0]), 32'(i0));
    chk({tag, "_i1"}, 32'(hs.idx[1]), 32'(i1));
    hs.ready = 1'b1;
    @(negedge clk_i);
    hs.ready = 1'b0;
  endtask

  task automatic start_run();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; hs.ready = 1'b0;
    code = '0; ro = '0;
    code[0] = 9'b01_00_00100;   // ADD r0 += ro0
    code[1] = 9'b00_00_00101;   // MOV r0 <= ro1
    code[2] = 9'b10_00_00100;   // SUB r0 -= ro0
    loop_addr[0] = 4'd0; loop_nops[0] = 5'd1;
    loop_addr[1] = 4'd1; loop_nops[1] = 5'd1;
    range_v[0] = 16'd3; range_v[1] = 16'd2;
    ro[0] = 32'd4; ro[1] = 32'd100;
    #3;
    chk("rst_valid", 32'(hs.valid), 32'd0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_done",  32'(done_o), 32'd0);
    chk("rst_offs",  hs.offs[0], 32'd0);
    chk("rst_idx",   32'(hs.idx[0]), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Nest of 3 x 2 with a stall on the second tuple.
    start_run();
    chk("start_lat", 32'(hs.valid), 32'd1);
    chk("start_busy", 32'(busy_o), 32'd1);
    tuple("t1", 32'd0, 16'd0, 16'd0);
    chk("exec_novld", 32'(hs.valid), 32'd0);
    @(negedge clk_i);
    chk("exec_lat", 32'(hs.valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_r0", hs.offs[0], 32'd4);
      chk("stall_i0", 32'(hs.idx[0]), 32'd1);
      chk("stall_i1", 32'(hs.idx[1]), 32'd0);
      @(negedge clk_i);
    end
    tuple("t2", 32'd4,   16'd1, 16'd0);
    tuple("t3", 32'd8,   16'd2, 16'd0);
    tuple("t4", 32'd100, 16'd0, 16'd1);
    tuple("t5", 32'd104, 16'd1, 16'd1);
    tuple("t6", 32'd108, 16'd2, 16'd1);
    chk("end_done",  32'(done_o), 32'd1);
    chk("end_busy",  32'(busy_o), 32'd0);
    chk("end_valid", 32'(hs.valid), 32'd0);
    chk("end_r0",    hs.offs[0], 32'd108);
    chk("end_i1",    32'(hs.idx[1]), 32'd1);
    @(negedge clk_i);
    chk("done_pulse", 32'(done_o), 32'd0);
    chk("no_extra",   32'(hs.valid), 32'd0);

    // Zero ranges: a single zero tuple, then done.
    range_v[0] = 16'd0; range_v[1] = 16'd0;
    start_run();
    tuple("z1", 32'd0, 16'd0, 16'd0);
    chk("z_done", 32'(done_o), 32'd1);
    chk("z_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);

    // Clear in the middle of a two-op body.
    range_v[0] = 16'd3; range_v[1] = 16'd2; loop_nops[0] = 5'd2;
    start_run();
    tuple("c1", 32'd0, 16'd0, 16'd0);
    @(negedge clk_i);
    chk("c_mid_r0", hs.offs[0], 32'd4);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("c_busy", 32'(busy_o), 32'd0);
    chk("c_r0",   hs.offs[0], 32'd0);
    chk("c_i0",   32'(hs.idx[0]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("c_nodone", 32'(done_o), 32'd0);
      chk("c_novld",  32'(hs.valid), 32'd0);
      @(negedge clk_i);
    end

    // start together with clear is ignored.
    start_i = 1'b1; clear_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; clear_i = 1'b0;
    chk("sc_busy", 32'(busy_o), 32'd0);
    chk("sc_vld",  32'(hs.valid), 32'd0);

    // Opcode 10 on r0 with ro0 = 1.
    loop_addr[0] = 4'd2; loop_nops[0] = 5'd1;
    range_v[0] = 16'd2; range_v[1] = 16'd1; ro[0] = 32'd1;
    start_run();
    tuple("s1", 32'd0, 16'd0, 16'd0);
    tuple("s2", SUB_EXP, 16'd1, 16'd0);
    chk("s_done", 32'(done_o), 32'd1);

    // Empty body on the outer loop.
    loop_addr[0] = 4'd0; loop_nops[1] = 5'd0; ro[0] = 32'd4;
    range_v[0] = 16'd1; range_v[1] = 16'd2;
    start_run();
    tuple("e1", 32'd0, 16'd0, 16'd0);
    chk("e_vld", 32'(hs.valid), 32'd1);
    chk("e_r0",  hs.offs[0], 32'd0);
    chk("e_i1",  32'(hs.idx[1]), 32'd1);
    chk("e_i0",  32'(hs.idx[0]), 32'd0);
    hs.ready = 1'b1;
    @(negedge clk_i);
    hs.ready = 1'b0;
    chk("e_done", 32'(done_o), 32'd1);

    // Reset mid-run does not resume.
    range_v[0] = 16'd3; range_v[1] = 16'd2; loop_nops[1] = 5'd1;
    start_run();
    tuple("r1", 32'd0, 16'd0, 16'd0);
    rst_ni = 1'b0;
    #1;
    chk("ar_valid", 32'(hs.valid), 32'd0);
    chk("ar_busy",  32'(busy_o), 32'd0);
    chk("ar_i0",    32'(hs.idx[0]), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("ar_idle", 32'(busy_o), 32'd0);
      chk("ar_novld", 32'(hs.valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
